// File: rtl/string_hw_avalon.sv
// string_hw_avalon: Avalon-MM slave exposing a 32-bit word FIFO for string chunks,
// with DATA push/pop, sticky STATUS flags, COUNT and CAPACITY registers.
module string_hw_avalon #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] writedata,
    input  logic [2:0]  address,
    output logic [31:0] readdata,
    input  logic        write,
    input  logic        read,
    input  logic        chipselect
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          overflow, underflow;
    logic          empty, full, cs_wr, cs_rd, push, pop, ovf_evt, unf_evt, status_clr;

    // A simultaneous write and read performs only the write.
    assign cs_wr      = chipselect & write;
    assign cs_rd      = chipselect & read & ~write;
    assign empty      = count == '0;
    assign full       = count == (AW+1)'(DEPTH);
    assign push       = cs_wr & (address == 3'd0) & ~full;
    assign ovf_evt    = cs_wr & (address == 3'd0) & full;
    assign pop        = cs_rd & (address == 3'd0) & ~empty;
    assign unf_evt    = cs_rd & (address == 3'd0) & empty;
    assign status_clr = cs_wr & (address == 3'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count     <= push ? count + 1'b1 : pop ? count - 1'b1 : count;
            overflow  <= status_clr ? 1'b0 : overflow | ovf_evt;
            underflow <= status_clr ? 1'b0 : underflow | unf_evt;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= writedata;
    end

    always_comb begin
        readdata = '0;
        if (cs_rd)
            readdata = (address == 3'd0) ? (empty ? 32'd0 : mem[rd_ptr]) :
                       (address == 3'd1) ? {28'd0, underflow, overflow, full, empty} :
                       (address == 3'd2) ? 32'(count) :
                       (address == 3'd3) ? 32'(DEPTH) : 32'd0;
    end
endmodule

// File: tb/tb_string_hw_avalon.sv
// tb_string_hw_avalon: directed self-checking bench for the string FIFO slave.
module tb_string_hw_avalon;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] writedata = '0;
    logic [2:0]  address = '0;
    logic [31:0] readdata;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic        chipselect = 1'b0;
    int          tests = 0;
    int          failed = 0;
    logic [31:0] v;

    string_hw_avalon #(.DEPTH(16)) dut (
        .clk(clk), .reset(reset), .writedata(writedata), .address(address),
        .readdata(readdata), .write(write), .read(read), .chipselect(chipselect)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = a;
        #1 d = readdata;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rd(3'd2, v); check("reset_count", v, 32'd0);
        rd(3'd1, v); check("reset_status", v, 32'h1);
        wr(3'd0, "abcd"); rd(3'd2, v); check("count1", v, 32'd1);
        wr(3'd0, "1234"); rd(3'd2, v); check("count2", v, 32'd2);
        wr(3'd0, "5678"); rd(3'd2, v); check("count3", v, 32'd3);
        wr(3'd0, "BEEF"); rd(3'd2, v); check("count4", v, 32'd4);
        rd(3'd0, v); check("pop_abcd", v, "abcd"); rd(3'd2, v); check("count_p3", v, 32'd3);
        rd(3'd0, v); check("pop_1234", v, "1234"); rd(3'd2, v); check("count_p2", v, 32'd2);
        rd(3'd0, v); check("pop_5678", v, "5678"); rd(3'd2, v); check("count_p1", v, 32'd1);
        rd(3'd0, v); check("pop_BEEF", v, "BEEF"); rd(3'd2, v); check("count_p0", v, 32'd0);
        for (int i = 0; i < 16; i++) wr(3'd0, 32'hA5000000 + i);
        wr(3'd0, 32'hDEADBEEF);
        rd(3'd2, v); check("full_count", v, 32'd16);
        rd(3'd1, v); check("full_status", v, 32'h6);
        for (int i = 0; i < 16; i++) begin
            rd(3'd0, v); check($sformatf("wrap_pop%0d", i), v, 32'hA5000000 + i);
        end
        rd(3'd2, v); check("drained_count", v, 32'd0);
        rd(3'd1, v); check("sticky_ovf", v, 32'h5);
        wr(3'd1, 32'h0); rd(3'd1, v); check("clr_ovf", v, 32'h1);
        rd(3'd0, v); check("empty_read", v, 32'd0);
        rd(3'd2, v); check("empty_count", v, 32'd0);
        rd(3'd1, v); check("underflow", v, 32'h9);
        wr(3'd1, 32'hFFFFFFFF); rd(3'd1, v); check("clr_unf", v, 32'h1);
        @(negedge clk);
        chipselect = 1'b0; write = 1'b1; address = 3'd0; writedata = 32'h11111111;
        @(negedge clk);
        write = 1'b0;
        rd(3'd2, v); check("no_cs_write", v, 32'd0);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; read = 1'b1; address = 3'd0; writedata = 32'hCAFEF00D;
        #1 check("rw_readdata", readdata, 32'd0);
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0; read = 1'b0;
        rd(3'd2, v); check("rw_count", v, 32'd1);
        rd(3'd0, v); check("rw_pop", v, 32'hCAFEF00D);
        wr(3'd5, 32'h12345678); rd(3'd5, v); check("reg5", v, 32'd0);
        rd(3'd2, v); check("reg5_no_push", v, 32'd0);
        wr(3'd0, "xxxx"); wr(3'd0, "yyyy"); wr(3'd0, "zzzz");
        rd(3'd2, v); check("pre_reset_count", v, 32'd3);
        @(posedge clk);
        #3 reset = 1'b0;
        #1 chipselect = 1'b1; read = 1'b1; address = 3'd2;
        #1 check("async_count", readdata, 32'd0);
        address = 3'd1;
        #1 check("async_status", readdata, 32'h1);
        chipselect = 1'b0; read = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        rd(3'd3, v); check("capacity", v, 32'd16);
        rd(3'd2, v); check("post_reset_count", v, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/string_hw_avalon.md
# string_hw_avalon

Avalon-MM slave wrapping a word-wide FIFO that buffers 32-bit string chunks (four ASCII characters per word) between a Nios II master and hardware string-processing logic. The master pushes words by writing the data register and pops them in order by reading the same register. Occupancy, status and capacity are readable at fixed register addresses.

## Interface
- DEPTH, 16, FIFO capacity in 32-bit words; power of two, ≥2.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- writedata  in  32  Avalon write data.
- address  in  3  word address of register.
- readdata  out  32  Avalon read data; zero read latency, no wait states.
- write  in  1  Avalon write strobe; qualified by chipselect.
- read  in  1  Avalon read strobe; qualified by chipselect.
- chipselect  in  1  slave select; when low, all accesses are ignored.

## Operation
- Register map:
  - 0 DATA: write pushes writedata; read returns the head word and pops it.
  - 1 STATUS: read {28'b0, underflow, overflow, full, empty}; any write clears the underflow and overflow bits.
  - 2 COUNT: read the current occupancy, 0..DEPTH, zero-extended.
  - 3 CAPACITY: read constant DEPTH.
  - 4–7: read 0; writes ignored.
- Storage: DEPTH×32 array with read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus a count register of log2(DEPTH)+1 bits.
- Push:
  - Occurs when chipselect & write & address==0 & !full.
  - Stores at the write pointer, increments it, count+1.
  - Push while full: data dropped, pointers and count unchanged, overflow sticky bit set.
- Pop:
  - Occurs when chipselect & read & address==0 & !empty.
  - Increments the read pointer, count−1.
  - Pop while empty: readdata=0, state unchanged, underflow sticky bit set.
- empty = (count==0); full = (count==DEPTH).
- Simultaneous write and read in one cycle (illegal on Avalon): write is performed, read is ignored, readdata=0.
- Reads of registers 1–3 have no side effects.

## Timing
- Reset asserted (low): pointers, count, overflow and underflow clear immediately, independent of clk. FIFO array contents are not reset.
- Reset mid-operation: any pending access is discarded. The first access honored is at the first rising edge after reset deasserts.
- readdata:
  - Combinational mux of address and the current state.
  - Valid in the same cycle that chipselect & read are high.
  - Forced to 0 whenever chipselect & read is low.
- A DATA read returns the pre-pop head. The pop takes effect at the rising edge that ends the read cycle, so a COUNT read in the next cycle shows the decremented value.
- A push is visible in COUNT and STATUS from the cycle after the write edge.
- Each cycle in which the strobe is high counts as one access. A strobe held for N cycles performs N pushes or N pops.
- Clearing sticky flags via a STATUS write takes effect at the write edge. If an overflow occurs in that same cycle, it is not possible, since that write targets address 1.

## Test plan
- Reset, then read COUNT → 0; read STATUS → 0x1 (empty).
- Write "abcd", "1234", "5678", "BEEF" to address 0 → COUNT reads 1, 2, 3, 4 after each write.
- Pop the FIFO loaded above with one-cycle DATA reads → readdata "abcd", then "1234", "5678", "BEEF". COUNT reads 3, 2, 1, 0 after each pop.
- Fill to DEPTH=16, then write 0xDEADBEEF → COUNT=16, STATUS=0x6 (full+overflow). Pop 16 words → original order preserved across pointer wrap; 0xDEADBEEF is never returned.
- Read DATA while empty → readdata=0, COUNT stays 0, STATUS=0x9. Write any value to STATUS → STATUS=0x1.
- Push 3 words, then assert reset low asynchronously mid-cycle → COUNT=0 and STATUS=0x1 immediately. Read CAPACITY → 16.
